// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin memory request arbiter with read-tag tracking
//
// Arbitrates line reads/writebacks from REQ_NUM requesters (0 = I-cache refill,
// 1..REQ_NUM-1 = D-cache MSHR entries) onto a single memory request channel.
// Reads are tagged with the requester index and tracked as pending until the
// matching response returns; writes complete at grant.
//
// Ports:
//   clk, rstN                      clock (rising edge), asynchronous active-low reset
//   reqValid/reqWrite/reqAddr/reqData  per-requester request (flattened vectors)
//   reqGrant                       one-hot, request latched this cycle
//   rspValid/rspData               registered one-hot read-data return
//   memReqValid/Write/Addr/Data/Tag, memReqReady   request channel to memory
//   memRspValid/Tag/Data           read-data channel from memory
//   pending                        outstanding-read bit per requester
//   protocolError                  sticky flag for unexpected responses
module mem_access_arbiter #(
    parameter int REQ_NUM    = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    localparam int TAG_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic [REQ_NUM-1:0]               reqValid,
    input  logic [REQ_NUM-1:0]               reqWrite,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]    reqAddr,
    input  logic [REQ_NUM*LINE_WIDTH-1:0]    reqData,
    output logic [REQ_NUM-1:0]               reqGrant,
    output logic [REQ_NUM-1:0]               rspValid,
    output logic [LINE_WIDTH-1:0]            rspData,
    output logic                             memReqValid,
    output logic                             memReqWrite,
    output logic [ADDR_WIDTH-1:0]            memReqAddr,
    output logic [LINE_WIDTH-1:0]            memReqData,
    output logic [TAG_WIDTH-1:0]             memReqTag,
    input  logic                             memReqReady,
    input  logic                             memRspValid,
    input  logic [TAG_WIDTH-1:0]             memRspTag,
    input  logic [LINE_WIDTH-1:0]            memRspData,
    output logic [REQ_NUM-1:0]               pending,
    output logic                             protocolError
);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_mem_write;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [LINE_WIDTH-1:0]   r_mem_data;
    logic [TAG_WIDTH-1:0]    r_mem_tag;
    logic [TAG_WIDTH-1:0]    r_rr_ptr;
    logic [REQ_NUM-1:0]      r_pending;
    logic [REQ_NUM-1:0]      r_rsp_valid;
    logic [LINE_WIDTH-1:0]   r_rsp_data;
    logic                    r_proto_err;

    logic [REQ_NUM-1:0]      w_eligible;
    logic                    w_can_pick;
    logic                    w_found;
    logic                    w_fire;
    logic [TAG_WIDTH-1:0]    w_win;
    logic [TAG_WIDTH-1:0]    w_win_next;
    logic                    w_sel_write;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [LINE_WIDTH-1:0]   w_sel_data;
    logic [REQ_NUM-1:0]      w_rd_accept;
    logic [REQ_NUM-1:0]      w_rsp_hit;
    logic                    w_rsp_bad;
    int                      w_idx;

    // The request currently stalled on the channel must not be picked again.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_eligible[i] = reqValid[i] & ~r_pending[i] &
                            ~((r_state == S_SEND) && (r_mem_tag == TAG_WIDTH'(i)) && !memReqReady);
        end
    end

    // A new request may be latched when idle, or when the current one is accepted.
    assign w_can_pick = (r_state == S_IDLE) || memReqReady;

    // Round-robin scan starting at r_rr_ptr.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_next = '0;
        w_idx      = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= REQ_NUM) w_idx = w_idx - REQ_NUM;
            if (!w_found && w_eligible[w_idx]) begin
                w_found    = 1'b1;
                w_win      = TAG_WIDTH'(w_idx);
                w_win_next = (w_idx + 1 >= REQ_NUM) ? '0 : TAG_WIDTH'(w_idx + 1);
            end
        end
    end

    assign w_fire = w_can_pick && w_found;

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_data  = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_win == TAG_WIDTH'(i)) begin
                w_sel_write = reqWrite[i];
                w_sel_addr  = reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data  = reqData[i*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_found ? S_SEND : S_IDLE;
            S_SEND:  if (memReqReady) w_state_nxt = w_found ? S_SEND : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs (grant is gated by reset so it is zero while rstN is low)
    always_comb begin
        memReqValid = (r_state == S_SEND);
        reqGrant    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            reqGrant[i] = rstN && w_fire && (w_win == TAG_WIDTH'(i));
        end
    end

    // Request registers only load on a grant, so they hold while stalled.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_tag   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_fire) begin
            r_mem_write <= w_sel_write;
            r_mem_addr  <= w_sel_addr;
            r_mem_data  <= w_sel_data;
            r_mem_tag   <= w_win;
            r_rr_ptr    <= w_win_next;
        end
    end

    // A response is valid only for a tag with a read outstanding; anything
    // else (including tags >= REQ_NUM) matches no bit and is an error.
    always_comb begin
        w_rd_accept = '0;
        w_rsp_hit   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            w_rd_accept[i] = (r_state == S_SEND) && memReqReady && !r_mem_write &&
                             (r_mem_tag == TAG_WIDTH'(i));
            w_rsp_hit[i]   = memRspValid && (memRspTag == TAG_WIDTH'(i)) && r_pending[i];
        end
    end

    assign w_rsp_bad = memRspValid && (w_rsp_hit == '0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pending   <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_pending   <= (r_pending | w_rd_accept) & ~w_rsp_hit;
            r_rsp_valid <= w_rsp_hit;
            if (|w_rsp_hit) r_rsp_data <= memRspData;
            r_proto_err <= r_proto_err | w_rsp_bad;
        end
    end

    assign memReqWrite   = r_mem_write;
    assign memReqAddr    = r_mem_addr;
    assign memReqData    = r_mem_data;
    assign memReqTag     = r_mem_tag;
    assign pending       = r_pending;
    assign rspValid      = r_rsp_valid;
    assign rspData       = r_rsp_data;
    assign protocolError = r_proto_err;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
module tb_mem_access_arbiter;

    localparam int RN = 3;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TW = 2;

    logic            clk;
    logic            rstN;
    logic [RN-1:0]   reqValid;
    logic [RN-1:0]   reqWrite;
    logic [RN*AW-1:0] reqAddr;
    logic [RN*LW-1:0] reqData;
    logic [RN-1:0]   reqGrant;
    logic [RN-1:0]   rspValid;
    logic [LW-1:0]   rspData;
    logic            memReqValid;
    logic            memReqWrite;
    logic [AW-1:0]   memReqAddr;
    logic [LW-1:0]   memReqData;
    logic [TW-1:0]   memReqTag;
    logic            memReqReady;
    logic            memRspValid;
    logic [TW-1:0]   memRspTag;
    logic [LW-1:0]   memRspData;
    logic [RN-1:0]   pending;
    logic            protocolError;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_d0;
    logic [LW-1:0] line_w2;

    mem_access_arbiter #(.REQ_NUM(RN), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rstN(rstN),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
        .reqGrant(reqGrant), .rspValid(rspValid), .rspData(rspData),
        .memReqValid(memReqValid), .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
        .memReqData(memReqData), .memReqTag(memReqTag), .memReqReady(memReqReady),
        .memRspValid(memRspValid), .memRspTag(memRspTag), .memRspData(memRspData),
        .pending(pending), .protocolError(protocolError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        reqWrite[i]        = w;
        reqAddr[i*AW +: AW] = a;
        reqData[i*LW +: LW] = d;
    endtask

    task automatic do_reset();
        rstN        = 1'b0;
        reqValid    = '0;
        reqWrite    = '0;
        memReqReady = 1'b0;
        memRspValid = 1'b0;
        memRspTag   = '0;
        cyc();
        rstN = 1'b1;
    endtask

    initial begin
        line_a5 = {8{32'hA5A5_A5A5}};
        line_d0 = {8{32'h0D0D_0D0D}};
        line_w2 = {8{32'h2222_CAFE}};
        rstN = 1'b0;
        reqValid = '0; reqWrite = '0; reqAddr = '0; reqData = '0;
        memReqReady = 1'b0; memRspValid = 1'b0; memRspTag = '0; memRspData = '0;

        // Reset state, with requests asserted during reset
        cyc();
        reqValid = 3'b111;
        #1;
        chk("rst_grant", reqGrant, 0);
        chk("rst_memReqValid", memReqValid, 0);
        chk("rst_pending", pending, 0);
        chk("rst_rspValid", rspValid, 0);
        chk("rst_rspData", rspData, 0);
        chk("rst_err", protocolError, 0);
        chk("rst_addr", memReqAddr, 0);
        chk("rst_tag", memReqTag, 0);
        reqValid = '0;
        rstN = 1'b1;

        // Single read from req1, response 4 cycles after acceptance
        cyc();
        memReqReady = 1'b1;
        set_req(1, 1'b0, 32'h0000_1000, '0);
        reqValid = 3'b010;
        #1;
        chk("a_grant_T", reqGrant, 3'b010);
        cyc();
        reqValid = '0;
        #1;
        chk("a_valid_T1", memReqValid, 1);
        chk("a_tag_T1", memReqTag, 1);
        chk("a_addr_T1", memReqAddr, 32'h0000_1000);
        chk("a_write_T1", memReqWrite, 0);
        chk("a_nogrant_T1", reqGrant, 0);
        cyc();
        #1;
        chk("a_pending_T2", pending, 3'b010);
        chk("a_idle_T2", memReqValid, 0);
        cyc();
        cyc();
        cyc();
        memRspValid = 1'b1; memRspTag = 2'd1; memRspData = line_a5;
        #1;
        chk("a_rspValid_T5", rspValid, 0);
        cyc();
        memRspValid = 1'b0; memRspData = '0;
        #1;
        chk("a_rspValid_T6", rspValid, 3'b010);
        chk("a_rspData_T6", rspData, line_a5);
        chk("a_pending_T6", pending, 0);
        chk("a_err_T6", protocolError, 0);
        cyc();
        #1;
        chk("a_rspValid_T7", rspValid, 0);
        chk("a_rspData_hold", rspData, line_a5);

        // Three reads from reset, back to back
        do_reset();
        cyc();
        memReqReady = 1'b1;
        set_req(0, 1'b0, 32'h100, '0);
        set_req(1, 1'b0, 32'h200, '0);
        set_req(2, 1'b0, 32'h300, '0);
        reqValid = 3'b111;
        #1;
        chk("b_grant0", reqGrant, 3'b001);
        cyc();
        reqValid = 3'b110;
        #1;
        chk("b_grant1", reqGrant, 3'b010);
        chk("b_tag0", memReqTag, 0);
        chk("b_addr0", memReqAddr, 32'h100);
        cyc();
        reqValid = 3'b100;
        #1;
        chk("b_grant2", reqGrant, 3'b100);
        chk("b_tag1", memReqTag, 1);
        chk("b_pend1", pending, 3'b001);
        cyc();
        reqValid = 3'b000;
        #1;
        chk("b_nogrant", reqGrant, 0);
        chk("b_tag2", memReqTag, 2);
        chk("b_pend2", pending, 3'b011);
        cyc();
        #1;
        chk("b_pend_all", pending, 3'b111);
        chk("b_idle", memReqValid, 0);

        // Backpressure: memReq* hold for 4 stalled cycles
        do_reset();
        cyc();
        memReqReady = 1'b0;
        set_req(0, 1'b0, 32'hA000, line_d0);
        set_req(1, 1'b0, 32'hB000, '0);
        reqValid = 3'b011;
        #1;
        chk("c_grant0", reqGrant, 3'b001);
        for (int n = 0; n < 4; n++) begin
            cyc();
            reqValid = 3'b010;
            set_req(0, 1'b0, 32'hDEAD_0000 + n, '0);
            #1;
            chk("c_stall_grant", reqGrant, 0);
            chk("c_stall_valid", memReqValid, 1);
            chk("c_stall_tag", memReqTag, 0);
            chk("c_stall_addr", memReqAddr, 32'hA000);
            chk("c_stall_data", memReqData, line_d0);
        end
        cyc();
        memReqReady = 1'b1;
        #1;
        chk("c_ready_grant", reqGrant, 3'b010);
        chk("c_ready_tag", memReqTag, 0);
        cyc();
        reqValid = '0;
        #1;
        chk("c_next_tag", memReqTag, 1);
        chk("c_next_addr", memReqAddr, 32'hB000);
        chk("c_pend", pending, 3'b001);

        // Write from req2: no pending, reissued write granted again
        cyc();
        set_req(2, 1'b1, 32'h2000, line_w2);
        reqValid = 3'b100;
        #1;
        chk("d_grant_w", reqGrant, 3'b100);
        chk("d_pend_pre", pending, 3'b011);
        cyc();
        #1;
        chk("d_write", memReqWrite, 1);
        chk("d_addr", memReqAddr, 32'h2000);
        chk("d_data", memReqData, line_w2);
        chk("d_tag", memReqTag, 2);
        chk("d_regrant", reqGrant, 3'b100);
        cyc();
        reqValid = '0;
        #1;
        chk("d_pend_mid", pending, 3'b011);
        chk("d_valid_2nd", memReqValid, 1);
        cyc();
        #1;
        chk("d_pend_post", pending, 3'b011);
        chk("d_idle", memReqValid, 0);

        // Unexpected responses
        do_reset();
        cyc();
        memRspValid = 1'b1; memRspTag = 2'd0; memRspData = line_a5;
        #1;
        chk("e_err_before", protocolError, 0);
        cyc();
        memRspTag = 2'd3;
        #1;
        chk("e_err_tag0", protocolError, 1);
        chk("e_rsp_tag0", rspValid, 0);
        cyc();
        memRspValid = 1'b0;
        #1;
        chk("e_err_tag3", protocolError, 1);
        chk("e_rsp_tag3", rspValid, 0);
        chk("e_rspData", rspData, 0);
        cyc();
        #1;
        chk("e_err_sticky", protocolError, 1);

        // Reset mid-SEND with reads outstanding
        do_reset();
        cyc();
        memReqReady = 1'b1;
        set_req(0, 1'b0, 32'h100, '0);
        set_req(1, 1'b0, 32'h200, '0);
        set_req(2, 1'b0, 32'h300, '0);
        reqValid = 3'b111;
        #1;
        chk("f_grant0", reqGrant, 3'b001);
        cyc();
        reqValid = 3'b110;
        #1;
        chk("f_grant1", reqGrant, 3'b010);
        cyc();
        reqValid = 3'b100;
        #1;
        chk("f_grant2", reqGrant, 3'b100);
        cyc();
        reqValid = '0;
        memReqReady = 1'b0;
        #1;
        chk("f_pend_pre", pending, 3'b011);
        chk("f_send_pre", memReqValid, 1);
        chk("f_tag_pre", memReqTag, 2);
        rstN = 1'b0;
        #1;
        chk("f_rst_valid", memReqValid, 0);
        chk("f_rst_pend", pending, 0);
        chk("f_rst_tag", memReqTag, 0);
        cyc();
        rstN = 1'b1;
        memRspValid = 1'b1; memRspTag = 2'd0; memRspData = line_a5;
        #1;
        cyc();
        memRspTag = 2'd1;
        #1;
        chk("f_err0", protocolError, 1);
        chk("f_rsp0", rspValid, 0);
        cyc();
        memRspValid = 1'b0;
        #1;
        chk("f_rsp1", rspValid, 0);
        chk("f_pend_post", pending, 0);
        chk("f_err1", protocolError, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 3: number of requesters (index 0 = I-cache refill, 1..REQ_NUM-1 = D-cache MSHR entries).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: memory address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256: line width in bits (8 words x 32).
REQ-004 SHALL derive localparam TAG_WIDTH = max(1, clog2(REQ_NUM)).
REQ-005 SHALL have ports, in this order:
  clk  in  1  sole clock, rising edge
  rstN  in  1  asynchronous reset, active-low
  reqValid  in  REQ_NUM  request present, per requester
  reqWrite  in  REQ_NUM  1 = line writeback, 0 = line read
  reqAddr  in  REQ_NUM*ADDR_WIDTH  per-requester address
  reqData  in  REQ_NUM*LINE_WIDTH  per-requester write data
  reqGrant  out  REQ_NUM  one-hot, request latched this cycle
  rspValid  out  REQ_NUM  one-hot read-data return
  rspData  out  LINE_WIDTH  returned line
  memReqValid  out  1  request to memory
  memReqWrite  out  1  write flag
  memReqAddr  out  ADDR_WIDTH  address
  memReqData  out  LINE_WIDTH  write data
  memReqTag  out  TAG_WIDTH  requester index
  memReqReady  in  1  memory accepts request
  memRspValid  in  1  read data from memory
  memRspTag  in  TAG_WIDTH  tag of returned data
  memRspData  in  LINE_WIDTH  returned line
  pending  out  REQ_NUM  outstanding-read bit per requester
  protocolError  out  1  sticky unexpected-response flag
REQ-006 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-007 SHALL implement FSM {IDLE, SEND}; memReqValid = (state == SEND).
REQ-008 SHALL define eligible[i] = reqValid[i] & !pending[i] & !(state==SEND & memReqTag==i & !memReqReady).
REQ-009 SHALL, in IDLE, or in SEND on the cycle memReqReady=1, pick the first eligible requester scanning from rrPtr upward modulo REQ_NUM, latch its write/addr/data/index into memReq* registers, assert reqGrant for that index combinationally in that cycle, and be in SEND next cycle.
REQ-010 SHALL, when no requester is eligible in that cycle, go to (or stay in) IDLE with reqGrant all zero.
REQ-011 SHALL update rrPtr to (winner+1) mod REQ_NUM on every grant; unchanged otherwise.
REQ-012 SHALL hold all memReq* outputs stable while memReqValid=1 and memReqReady=0.
REQ-013 SHALL set pending[tag] at the edge where memReqValid & memReqReady & !memReqWrite.
REQ-014 SHALL treat a write as complete at grant; writes never set pending.
REQ-015 SHALL, on memRspValid with pending[memRspTag]=1, clear pending[memRspTag] and assert rspValid[memRspTag] with rspData = memRspData exactly one cycle later (registered, 1-cycle pulse).
REQ-016 SHALL, on memRspValid with memRspTag >= REQ_NUM or pending[memRspTag]=0, set protocolError (sticky until reset), leave pending unchanged, assert no rspValid.
REQ-017 SHALL evaluate eligibility from registered pending: a requester whose pending clears at edge N is eligible from cycle N onward, never same cycle as the response.
REQ-018 SHALL sustain one request per cycle when memReqReady is held 1 and eligible requesters exist.
REQ-019 SHALL keep rspData unchanged when no rspValid bit is set.

Reset
REQ-020 SHALL, while rstN=0, force immediately: state IDLE, memReqValid 0, memReqWrite 0, memReqAddr/Data/Tag 0, rrPtr 0, pending 0, rspValid 0, rspData 0, protocolError 0; reqGrant 0.
REQ-021 SHALL discard any in-flight SEND request on reset; first grant possible in the first cycle after rstN rises.

Verification
REQ-022 Read from req1, addr 0x0000_1000, ready=1: reqGrant=3'b010 cycle T; memReqValid/tag=1 at T+1; pending[1]=1 after T+1; memRsp tag1 data 0xA5..A5 at T+5 -> rspValid=3'b010, rspData 0xA5..A5 at T+6, pending[1]=0.
REQ-023 All three reads valid from reset, ready=1: grants 001,010,100 on consecutive cycles; memReqTag 0,1,2; no grant 4th cycle (all pending).
REQ-024 memReqReady=0 for 4 cycles during SEND: memReq* stable, no reqGrant; ready=1 -> next eligible granted that same cycle.
REQ-025 Write from req2 addr 0x2000: granted, accepted, pending stays 0; req2 reissues and is granted again on the next round-robin turn.
REQ-026 memRspValid tag 0 with pending 0, then tag 3: protocolError=1 and stays 1, rspValid stays 0.
REQ-027 rstN dropped mid-SEND with pending=3'b011: memReqValid and pending 0 immediately, no rspValid for later memRsp of those tags (protocolError set).
